// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings for the write-back stage: load sizes, FSM states, link register.
package wb_stage_pipe_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    // Link register is all-ones; sliced down to the register-address width at use.
    localparam logic [31:0] LINK_REG = '1;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size[1])
            misaligned = (addr_lo != 2'b00);
        else if (size == SZ_HALF)
            misaligned = addr_lo[0];
        else
            misaligned = 1'b0;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_load_filter.sv
// Little-endian sub-word extraction and sign/zero extension of load data.
module load_filter
    import wb_stage_pipe_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] i_rdata,
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_addr_lo,
    input  logic             i_zero_extend,
    output logic [NBITS-1:0] o_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = i_rdata[{i_addr_lo, 3'b000} +: 8];
        half_v = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
        if (i_size[1])
            o_data = i_rdata;
        else if (i_size == SZ_HALF)
            o_data = {{(NBITS-16){~i_zero_extend & half_v[15]}}, half_v};
        else
            o_data = {{(NBITS-8){~i_zero_extend & byte_v[7]}}, byte_v};
    end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB write-back stage: result select, load wait with timeout, retire counter.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int REGS         = 5,
    parameter int CNTBITS      = 32,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_flush,
    input  logic               i_reg_write,
    input  logic               i_lui,
    input  logic [NBITS-1:0]   i_extend,
    input  logic               i_mem_to_reg,
    input  logic [1:0]         i_size,
    input  logic               i_zero_extend,
    input  logic [1:0]         i_addr_lo,
    input  logic [NBITS-1:0]   i_alu,
    input  logic               i_jal,
    input  logic [NBITS-1:0]   i_pc8,
    input  logic [REGS-1:0]    i_rd,
    input  logic               i_mem_rvalid,
    input  logic [NBITS-1:0]   i_mem_rdata,
    output logic               o_rf_we,
    output logic [REGS-1:0]    o_rf_waddr,
    output logic [NBITS-1:0]   o_rf_wdata,
    output logic [CNTBITS-1:0] o_retired,
    output logic               o_err_align,
    output logic               o_err_timeout
);

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(LOAD_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               rf_we_q, rf_we_d;
    logic [REGS-1:0]    waddr_q, waddr_d;
    logic [NBITS-1:0]   wdata_q, wdata_d;
    logic [CNTBITS-1:0] retired_q, retired_d;
    logic               err_align_q, err_align_d;
    logic               err_to_q, err_to_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [1:0]         ld_size_q, ld_size_d;
    logic [1:0]         ld_addr_q, ld_addr_d;
    logic               ld_zext_q, ld_zext_d;
    logic [REGS-1:0]    ld_rd_q, ld_rd_d;
    logic               ld_we_q, ld_we_d;

    logic               accept, is_load;
    logic [REGS-1:0]    dest;
    logic [NBITS-1:0]   result, ld_data;

    // The filter only ever sees the controls captured when the load was accepted.
    load_filter #(.NBITS(NBITS)) u_filter (
        .i_rdata       (i_mem_rdata),
        .i_size        (ld_size_q),
        .i_addr_lo     (ld_addr_q),
        .i_zero_extend (ld_zext_q),
        .o_data        (ld_data)
    );

    assign o_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        rf_we_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        retired_d   = retired_q;
        err_align_d = err_align_q;
        err_to_d    = err_to_q;
        tcnt_d      = tcnt_q;
        ld_size_d   = ld_size_q;
        ld_addr_d   = ld_addr_q;
        ld_zext_d   = ld_zext_q;
        ld_rd_d     = ld_rd_q;
        ld_we_d     = ld_we_q;

        accept  = i_valid && (state_q == IDLE) && !i_flush;
        is_load = i_mem_to_reg && !i_lui && !i_jal;
        dest    = i_jal ? LINK_REG[REGS-1:0] : i_rd;
        result  = i_jal ? i_pc8 : (i_lui ? i_extend : i_alu);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_load && misaligned(i_size, i_addr_lo)) begin
                        err_align_d = 1'b1;
                        retired_d   = retired_q + 1'b1;
                    end else if (is_load) begin
                        state_d   = WAIT_LOAD;
                        tcnt_d    = '0;
                        ld_size_d = i_size;
                        ld_addr_d = i_addr_lo;
                        ld_zext_d = i_zero_extend;
                        ld_rd_d   = i_rd;
                        ld_we_d   = i_reg_write;
                    end else begin
                        retired_d = retired_q + 1'b1;
                        if (i_reg_write && dest != '0) begin
                            rf_we_d = 1'b1;
                            waddr_d = dest;
                            wdata_d = result;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (i_flush) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (i_mem_rvalid) begin
                    state_d   = IDLE;
                    tcnt_d    = '0;
                    retired_d = retired_q + 1'b1;
                    if (ld_we_q && ld_rd_q != '0) begin
                        rf_we_d = 1'b1;
                        waddr_d = ld_rd_q;
                        wdata_d = ld_data;
                    end
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d   = IDLE;
                    tcnt_d    = '0;
                    err_to_d  = 1'b1;
                    retired_d = retired_q + 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rf_we_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            retired_q   <= '0;
            err_align_q <= 1'b0;
            err_to_q    <= 1'b0;
            tcnt_q      <= '0;
            ld_size_q   <= '0;
            ld_addr_q   <= '0;
            ld_zext_q   <= 1'b0;
            ld_rd_q     <= '0;
            ld_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            retired_q   <= retired_d;
            err_align_q <= err_align_d;
            err_to_q    <= err_to_d;
            tcnt_q      <= tcnt_d;
            ld_size_q   <= ld_size_d;
            ld_addr_q   <= ld_addr_d;
            ld_zext_q   <= ld_zext_d;
            ld_rd_q     <= ld_rd_d;
            ld_we_q     <= ld_we_d;
        end
    end

    assign o_rf_we       = rf_we_q;
    assign o_rf_waddr    = waddr_q;
    assign o_rf_wdata    = wdata_q;
    assign o_retired     = retired_q;
    assign o_err_align   = err_align_q;
    assign o_err_timeout = err_to_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe; narrow retire counter so wrap-around is reachable.
module tb_wb_stage_pipe;

    localparam int NBITS = 32;
    localparam int REGS  = 5;
    localparam int CB    = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n, i_valid, i_flush, i_reg_write, i_lui, i_mem_to_reg;
    logic              i_zero_extend, i_jal, i_mem_rvalid;
    logic [1:0]        i_size, i_addr_lo;
    logic [NBITS-1:0]  i_extend, i_alu, i_pc8, i_mem_rdata;
    logic [REGS-1:0]   i_rd;
    logic              o_ready, o_rf_we, o_err_align, o_err_timeout;
    logic [REGS-1:0]   o_rf_waddr;
    logic [NBITS-1:0]  o_rf_wdata;
    logic [CB-1:0]     o_retired;

    int          vectors = 0;
    int          miscompares = 0;
    logic [CB-1:0] exp_ret;

    always #5 i_clk = ~i_clk;

    wb_stage_pipe #(.NBITS(NBITS), .REGS(REGS), .CNTBITS(CB), .LOAD_TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_reg_write(i_reg_write), .i_lui(i_lui), .i_extend(i_extend),
        .i_mem_to_reg(i_mem_to_reg), .i_size(i_size), .i_zero_extend(i_zero_extend),
        .i_addr_lo(i_addr_lo), .i_alu(i_alu), .i_jal(i_jal), .i_pc8(i_pc8), .i_rd(i_rd),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_rf_we(o_rf_we),
        .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_retired(o_retired),
        .o_err_align(o_err_align), .o_err_timeout(o_err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr();
        i_valid = 0; i_flush = 0; i_reg_write = 0; i_lui = 0; i_mem_to_reg = 0;
        i_zero_extend = 0; i_jal = 0; i_mem_rvalid = 0; i_size = 2'b00; i_addr_lo = 2'b00;
        i_extend = '0; i_alu = '0; i_pc8 = '0; i_mem_rdata = '0; i_rd = '0;
    endtask

    task automatic issue_load(input logic [1:0] sz, input logic [1:0] al, input logic zx,
                              input logic [REGS-1:0] rd);
        clr();
        i_valid = 1; i_mem_to_reg = 1; i_reg_write = 1;
        i_size = sz; i_addr_lo = al; i_zero_extend = zx; i_rd = rd;
        tick();
        i_valid = 0;
    endtask

    initial begin
        clr();
        i_rst_n = 0;
        #12;
        chk("rst_we", o_rf_we, 0);
        chk("rst_waddr", o_rf_waddr, 0);
        chk("rst_wdata", o_rf_wdata, 0);
        chk("rst_retired", o_retired, 0);
        chk("rst_errs", {o_err_align, o_err_timeout}, 0);
        chk("rst_ready", o_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1;
        tick();
        exp_ret = 0;

        // ALU op
        i_valid = 1; i_alu = 32'h1234_5678; i_rd = 5; i_reg_write = 1;
        tick(); exp_ret++;
        chk("alu_we", o_rf_we, 1);
        chk("alu_waddr", o_rf_waddr, 5);
        chk("alu_wdata", o_rf_wdata, 32'h1234_5678);
        chk("alu_ret", o_retired, exp_ret);
        clr();
        tick();
        chk("alu_pulse", o_rf_we, 0);
        chk("alu_hold", o_rf_wdata, 32'h1234_5678);

        // signed byte load, data three cycles after acceptance
        issue_load(2'b00, 2'd2, 1'b0, 5'd3);
        chk("lb_ready0", o_ready, 0);
        chk("lb_nowe", o_rf_we, 0);
        tick(); tick();
        chk("lb_ready_wait", o_ready, 0);
        i_mem_rvalid = 1; i_mem_rdata = 32'h0080_0000;
        tick(); exp_ret++;
        i_mem_rvalid = 0;
        chk("lb_we", o_rf_we, 1);
        chk("lb_waddr", o_rf_waddr, 3);
        chk("lb_wdata", o_rf_wdata, 32'hFFFF_FF80);
        chk("lb_ret", o_retired, exp_ret);
        chk("lb_ready1", o_ready, 1);

        issue_load(2'b00, 2'd2, 1'b1, 5'd3);
        tick(); tick();
        i_mem_rvalid = 1; i_mem_rdata = 32'h0080_0000;
        tick(); exp_ret++;
        i_mem_rvalid = 0;
        chk("lbu_wdata", o_rf_wdata, 32'h0000_0080);
        chk("lbu_ret", o_retired, exp_ret);

        // JAL
        clr();
        i_valid = 1; i_jal = 1; i_pc8 = 32'h0040_0008; i_rd = 7; i_reg_write = 1;
        i_alu = 32'hAAAA_AAAA;
        tick(); exp_ret++;
        clr();
        chk("jal_we", o_rf_we, 1);
        chk("jal_waddr", o_rf_waddr, 31);
        chk("jal_wdata", o_rf_wdata, 32'h0040_0008);

        // misaligned half
        issue_load(2'b01, 2'd1, 1'b0, 5'd9);
        exp_ret++;
        chk("mis_we", o_rf_we, 0);
        chk("mis_err", o_err_align, 1);
        chk("mis_ret", o_retired, exp_ret);
        chk("mis_ready", o_ready, 1);

        // word load timeout
        issue_load(2'b10, 2'd0, 1'b0, 5'd9);
        for (int k = 0; k < 14; k++) tick();
        chk("to_ready_pre", o_ready, 0);
        chk("to_err_pre", o_err_timeout, 0);
        tick(); exp_ret++;
        chk("to_err", o_err_timeout, 1);
        chk("to_ready", o_ready, 1);
        chk("to_we", o_rf_we, 0);
        chk("to_ret", o_retired, exp_ret);
        chk("align_sticky", o_err_align, 1);

        // flush coincident with rvalid, then late rvalid
        issue_load(2'b10, 2'd0, 1'b0, 5'd4);
        i_flush = 1; i_mem_rvalid = 1; i_mem_rdata = 32'hDEAD_BEEF;
        tick();
        i_flush = 0;
        chk("fl_we", o_rf_we, 0);
        chk("fl_ret", o_retired, exp_ret);
        chk("fl_ready", o_ready, 1);
        tick();
        i_mem_rvalid = 0;
        chk("late_we", o_rf_we, 0);
        chk("late_ret", o_retired, exp_ret);
        chk("late_wdata", o_rf_wdata, 32'h0040_0008);

        // rd=0 gated write still retires
        clr();
        i_valid = 1; i_reg_write = 1; i_rd = 0; i_alu = 32'h5555_0000;
        tick(); exp_ret++;
        chk("r0_we", o_rf_we, 0);
        chk("r0_ret", o_retired, exp_ret);
        chk("r0_waddr", o_rf_waddr, 31);

        // back-to-back ALU ops through counter wrap
        i_rd = 1;
        while (exp_ret != '1) begin
            i_alu = 32'h100 + 32'(exp_ret);
            tick(); exp_ret++;
            chk("run_ret", o_retired, exp_ret);
        end
        i_alu = 32'h0000_0BAD;
        tick();
        chk("wrap_ret", o_retired, 0);
        chk("wrap_wdata", o_rf_wdata, 32'h0000_0BAD);
        clr();

        // reset in the middle of a load wait
        issue_load(2'b10, 2'd0, 1'b0, 5'd6);
        chk("rw_ready", o_ready, 0);
        #2;
        i_rst_n = 0;
        #1;
        chk("rw_we", o_rf_we, 0);
        chk("rw_waddr", o_rf_waddr, 0);
        chk("rw_wdata", o_rf_wdata, 0);
        chk("rw_ret", o_retired, 0);
        chk("rw_errs", {o_err_align, o_err_timeout}, 0);
        chk("rw_ready1", o_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1;
        i_mem_rvalid = 1; i_mem_rdata = 32'h1111_2222;
        tick();
        i_mem_rvalid = 0;
        chk("rw_discard_we", o_rf_we, 0);
        chk("rw_discard_ret", o_retired, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 SHALL have parameter NBITS, default 32: datapath width.
REQ-002 SHALL have parameter REGS, default 5: register-address width.
REQ-003 SHALL have parameter CNTBITS, default 32: retired-instruction counter width.
REQ-004 SHALL have parameter LOAD_TIMEOUT, default 15: maximum cycles to wait for load data.
REQ-005 SHALL have ports:
  i_clk  in  1  sole clock, rising edge
  i_rst_n  in  1  asynchronous active-low reset
  i_valid  in  1  MEM/WB instruction present
  o_ready  out  1  stage accepts instruction
  i_flush  in  1  discard accepted or pending instruction
  i_reg_write  in  1  instruction writes register file
  i_lui  in  1  result is i_extend
  i_extend  in  NBITS  upper-immediate value
  i_mem_to_reg  in  1  instruction is a load
  i_size  in  2  00 byte, 01 half, 1x word
  i_zero_extend  in  1  zero- (1) / sign- (0) extend
  i_addr_lo  in  2  load address bits [1:0]
  i_alu  in  NBITS  ALU result
  i_jal  in  1  link instruction
  i_pc8  in  NBITS  return address
  i_rd  in  REGS  destination register
  i_mem_rvalid  in  1  load data valid
  i_mem_rdata  in  NBITS  load data
  o_rf_we  out  1  register-file write enable
  o_rf_waddr  out  REGS  write address
  o_rf_wdata  out  NBITS  write data
  o_retired  out  CNTBITS  completed-instruction count
  o_err_align  out  1  sticky misaligned-load flag
  o_err_timeout  out  1  sticky load-timeout flag

Function
REQ-006 SHALL accept an instruction when i_valid and o_ready are both 1; o_ready SHALL be 1 only in state IDLE.
REQ-007 SHALL select result with priority: i_jal -> i_pc8; i_lui -> i_extend; i_mem_to_reg -> filtered load; else i_alu.
REQ-008 SHALL force destination address to all-ones (register 31) when i_jal is 1, else i_rd.
REQ-009 SHALL, for a non-waiting instruction, drive o_rf_we/o_rf_waddr/o_rf_wdata registered one cycle after acceptance.
REQ-010 SHALL enter WAIT_LOAD on accepting an instruction with i_mem_to_reg=1, i_lui=0, i_jal=0, capturing all controls.
REQ-011 SHALL, in WAIT_LOAD on i_mem_rvalid, filter i_mem_rdata, write it one cycle later, and return to IDLE.
REQ-012 SHALL filter little-endian: byte = rdata[8*addr_lo +: 8]; half = rdata[16*addr_lo[1] +: 16]; word = rdata; extend per i_zero_extend.
REQ-013 SHALL treat half with addr_lo[0]=1 or word with addr_lo!=0 as misaligned: no write, set o_err_align, return to IDLE.
REQ-014 SHALL count WAIT_LOAD cycles; after LOAD_TIMEOUT cycles without i_mem_rvalid, set o_err_timeout, suppress write, return to IDLE.
REQ-015 SHALL gate o_rf_we to 0 when i_reg_write=0 or destination address is 0; o_rf_we SHALL be a single-cycle pulse.
REQ-016 SHALL, on i_flush, drop the instruction being accepted or pending in WAIT_LOAD, not write it, not count it, go to IDLE; flush wins over simultaneous i_mem_rvalid.
REQ-017 SHALL ignore i_mem_rvalid while in IDLE.
REQ-018 SHALL increment o_retired by one in the cycle each non-flushed instruction completes (written, gated, misaligned or timed-out), wrapping modulo 2^CNTBITS.
REQ-019 SHALL keep o_rf_waddr/o_rf_wdata holding the last value when o_rf_we=0.

Reset
REQ-020 SHALL, while i_rst_n=0, asynchronously force state IDLE, o_rf_we=0, o_rf_waddr=0, o_rf_wdata=0, o_retired=0, both error flags 0, timeout counter 0; reset mid-WAIT_LOAD SHALL discard the load.
REQ-021 SHALL clear error flags only by reset.

Structure
REQ-022 SHALL place size encodings, state encoding and the link-register constant in a shared package.
REQ-023 SHALL implement the combinational load filter as one sub-module, load_filter.

Verification
REQ-024 ALU op: i_alu=0x1234_5678, i_rd=5, reg_write=1 -> next cycle o_rf_we=1, waddr=5, wdata=0x1234_5678, o_retired +1.
REQ-025 Load byte signed, addr_lo=2, rvalid 3 cycles later with rdata=0x0080_0000 -> o_ready=0 for wait, then wdata=0xFFFF_FF80; zero_extend=1 -> 0x0000_0080.
REQ-026 JAL, i_pc8=0x0040_0008, i_rd=7 -> waddr=31, wdata=0x0040_0008.
REQ-027 Load half addr_lo=1 -> o_rf_we stays 0, o_err_align=1, counter +1; word with no rvalid for 15 cycles -> o_err_timeout=1, o_ready returns 1.
REQ-028 Flush in WAIT_LOAD coincident with rvalid -> no write, counter unchanged, late rvalid ignored; i_rst_n low mid-wait -> all outputs zero immediately.
REQ-029 i_rd=0 with reg_write=1 -> o_rf_we=0, counter +1; counter at all-ones +1 -> wraps to 0.
